// File: rtl/mc_mainfsm_pkg.sv
// Shared control types and constants for the multicycle ARM controller.
// Holds the state encoding, datapath mux selects, opcode classes and the retire rule.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] ALUSRCA_REG   = 2'd0;
  localparam logic [1:0] ALUSRCA_PC    = 2'd1;
  localparam logic [1:0] ALUSRCB_REG   = 2'd0;
  localparam logic [1:0] ALUSRCB_IMM   = 2'd1;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'd2;
  localparam logic [1:0] RESULT_ALUOUT = 2'd0;
  localparam logic [1:0] RESULT_RDATA  = 2'd1;
  localparam logic [1:0] RESULT_ALU    = 2'd2;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // An instruction retires on the cycle it leaves its final state.
  function automatic logic retires(input state_t s, input logic mem_ready);
    case (s)
      S_MEMWB, S_ALUWB, S_BRANCH: retires = 1'b1;
      S_MEMWR:                    retires = mem_ready;
      default:                    retires = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_mainfsm_if.sv
// Controller <-> datapath/memory bundle: instruction fields, memory handshake and control outputs.
interface mc_mainfsm_if #(parameter int INSTRET_W = 32) ();
  logic [1:0]           Op;
  logic [5:0]           Funct;
  logic                 MemReady;
  logic                 IRWrite;
  logic                 NextPC;
  logic                 AdrSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ResultSrc;
  logic                 ALUOp;
  logic                 RegW;
  logic                 MemW;
  logic                 Branch;
  logic                 Illegal;
  logic [INSTRET_W-1:0] Instret;
  logic [3:0]           State;

  modport master (
    input  Op, Funct, MemReady,
    output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           ALUOp, RegW, MemW, Branch, Illegal, Instret, State
  );

  modport slave (
    output Op, Funct, MemReady,
    input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           ALUOp, RegW, MemW, Branch, Illegal, Instret, State
  );
endinterface

// File: rtl/mc_mainfsm_flopr.sv
// Resettable register with synchronous active-low reset to a configurable value.
module mc_mainfsm_flopr #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= RESET_VAL;
    else        q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/mc_mainfsm_instret_ctr.sv
// Retired-instruction counter; wraps naturally at 2^W.
module instret_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n)     count_q <= '0;
    else if (inc_i) count_q <= count_q + W'(1);
    else            count_q <= count_q;
  end

  assign count_o = count_q;
endmodule

// File: rtl/mc_mainfsm.sv
// Multicycle ARM main control FSM: Moore decode of the state register, with the
// fetch-stage IR/PC writes gated by the memory-ready handshake.
module mc_mainfsm
  import arm_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  mc_mainfsm_if.master bus
);
  logic [3:0]           state_raw;
  state_t               state_q;
  state_t               state_d;
  logic [INSTRET_W-1:0] instret_s;

  logic       irwrite_s, nextpc_s, adrsrc_s, aluop_s;
  logic       regw_s, memw_s, branch_s, illegal_s;
  logic [1:0] srca_s, srcb_s, result_s;

  mc_mainfsm_flopr #(.WIDTH(4), .RESET_VAL(4'd0)) u_state (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (state_d),
    .q_o   (state_raw)
  );

  assign state_q = state_t'(state_raw);

  instret_ctr #(.W(INSTRET_W)) u_instret (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (retires(state_q, bus.MemReady)),
    .count_o (instret_s)
  );

  // Next-state and per-state control decode.
  always_comb begin
    state_d   = S_FETCH;
    irwrite_s = 1'b0;
    nextpc_s  = 1'b0;
    adrsrc_s  = 1'b0;
    srca_s    = ALUSRCA_REG;
    srcb_s    = ALUSRCB_REG;
    result_s  = RESULT_ALUOUT;
    aluop_s   = 1'b0;
    regw_s    = 1'b0;
    memw_s    = 1'b0;
    branch_s  = 1'b0;
    illegal_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        srca_s    = ALUSRCA_PC;
        srcb_s    = ALUSRCB_FOUR;
        result_s  = RESULT_ALU;
        irwrite_s = bus.MemReady;
        nextpc_s  = bus.MemReady;
        state_d   = bus.MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        srca_s   = ALUSRCA_PC;
        srcb_s   = ALUSRCB_FOUR;
        result_s = RESULT_ALU;
        case (bus.Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        srcb_s  = ALUSRCB_IMM;
        state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adrsrc_s = 1'b1;
        state_d  = bus.MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        result_s = RESULT_RDATA;
        regw_s   = 1'b1;
      end
      S_MEMWR: begin
        adrsrc_s = 1'b1;
        memw_s   = 1'b1;
        state_d  = bus.MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXECUTER: begin
        aluop_s = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        srcb_s  = ALUSRCB_IMM;
        aluop_s = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: regw_s = 1'b1;
      S_BRANCH: begin
        srcb_s   = ALUSRCB_IMM;
        result_s = RESULT_ALU;
        branch_s = 1'b1;
      end
      S_UNKNOWN: illegal_s = 1'b1;
      default:   state_d = S_FETCH;
    endcase
  end

  // While reset is held the outputs present an idle FETCH with no writes.
  assign bus.IRWrite   = reset & irwrite_s;
  assign bus.NextPC    = reset & nextpc_s;
  assign bus.AdrSrc    = reset & adrsrc_s;
  assign bus.ALUSrcA   = reset ? srca_s   : ALUSRCA_PC;
  assign bus.ALUSrcB   = reset ? srcb_s   : ALUSRCB_FOUR;
  assign bus.ResultSrc = reset ? result_s : RESULT_ALU;
  assign bus.ALUOp     = reset & aluop_s;
  assign bus.RegW      = reset & regw_s;
  assign bus.MemW      = reset & memw_s;
  assign bus.Branch    = reset & branch_s;
  assign bus.Illegal   = reset & illegal_s;
  assign bus.Instret   = reset ? instret_s : '0;
  assign bus.State     = reset ? state_raw : 4'd0;

endmodule

// File: tb/tb_mc_mainfsm.sv
// Scoreboard bench for mc_mainfsm: instruction-level plans expand into per-cycle
// stimulus and expectations; a negedge monitor pops and compares.
module tb_mc_mainfsm;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mc_mainfsm_if #(.INSTRET_W(W)) bus ();
  mc_mainfsm #(.INSTRET_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit         rst;
    logic [1:0] op;
    logic [5:0] funct;
    bit         mr;
    int         st;
    int         ir;
  } cyc_t;

  cyc_t stim_q[$];
  cyc_t exp_q[$];
  int   model_ir = 0;
  int   total = 0;
  int   bad = 0;

  function automatic logic [1:0] rop();
    return 2'($urandom_range(0, 3));
  endfunction
  function automatic logic [5:0] rfn();
    return 6'($urandom_range(0, 63));
  endfunction
  function automatic bit rmr();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic issue(input bit rst, input logic [1:0] op, input logic [5:0] funct,
                       input bit mr, input int st);
    cyc_t c;
    c.rst = rst; c.op = op; c.funct = funct; c.mr = mr;
    c.st = rst ? 0 : st;
    c.ir = rst ? 0 : model_ir;
    stim_q.push_back(c);
    exp_q.push_back(c);
    if (rst) model_ir = 0;
  endtask

  task automatic retire();
    model_ir = (model_ir + 1) % (1 << W);
  endtask

  task automatic do_fetch(input int stalls);
    for (int i = 0; i < stalls; i++) issue(1'b0, rop(), rfn(), 1'b0, 0);
    issue(1'b0, rop(), rfn(), 1'b1, 0);
  endtask

  // kind: 0 DP reg, 1 DP imm, 2 LDR, 3 STR, 4 B, 5 illegal
  task automatic run_instr(input int kind, input int fst, input int mst);
    logic [5:0] f;
    do_fetch(fst);
    f = rfn();
    case (kind)
      0, 1: begin
        f[5] = (kind == 1);
        issue(1'b0, 2'b00, f, rmr(), 1);
        issue(1'b0, rop(), rfn(), rmr(), (kind == 1) ? 7 : 6);
        issue(1'b0, rop(), rfn(), rmr(), 8);
        retire();
      end
      2, 3: begin
        issue(1'b0, 2'b01, rfn(), rmr(), 1);
        f[0] = (kind == 2);
        issue(1'b0, rop(), f, rmr(), 2);
        for (int i = 0; i < mst; i++) issue(1'b0, rop(), rfn(), 1'b0, (kind == 2) ? 3 : 5);
        issue(1'b0, rop(), rfn(), 1'b1, (kind == 2) ? 3 : 5);
        if (kind == 2) issue(1'b0, rop(), rfn(), rmr(), 4);
        retire();
      end
      4: begin
        issue(1'b0, 2'b10, f, rmr(), 1);
        issue(1'b0, rop(), rfn(), rmr(), 9);
        retire();
      end
      default: begin
        issue(1'b0, 2'b11, f, rmr(), 1);
        issue(1'b0, rop(), rfn(), rmr(), 10);
      end
    endcase
  endtask

  // Expected control word {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch,Illegal}.
  function automatic logic [13:0] exp_out(input bit rst, input int st, input bit mr);
    logic irw, npc, adr, aop, rw, mw, br, ill;
    logic [1:0] sa, sb, rs;
    {irw, npc, adr, aop, rw, mw, br, ill} = 8'd0;
    sa = 2'd0; sb = 2'd0; rs = 2'd0;
    if (rst) begin
      sa = 2'd1; sb = 2'd2; rs = 2'd2;
    end else begin
      case (st)
        0:  begin sa = 2'd1; sb = 2'd2; rs = 2'd2; irw = mr; npc = mr; end
        1:  begin sa = 2'd1; sb = 2'd2; rs = 2'd2; end
        2:  sb = 2'd1;
        3:  adr = 1'b1;
        4:  begin rs = 2'd1; rw = 1'b1; end
        5:  begin adr = 1'b1; mw = 1'b1; end
        6:  aop = 1'b1;
        7:  begin sb = 2'd1; aop = 1'b1; end
        8:  rw = 1'b1;
        9:  begin sb = 2'd1; rs = 2'd2; br = 1'b1; end
        10: ill = 1'b1;
        default: ;
      endcase
    end
    return {irw, npc, adr, sa, sb, rs, aop, rw, mw, br, ill};
  endfunction

  // Plan building and stimulus driving.
  initial begin
    cyc_t c;
    bus.Op = 2'b00; bus.Funct = 6'd0; bus.MemReady = 1'b0;
    issue(1'b1, rop(), rfn(), 1'b0, 0);
    issue(1'b1, rop(), rfn(), 1'b1, 0);
    run_instr(0, 0, 0);
    run_instr(2, 0, 2);
    run_instr(3, 1, 0);
    run_instr(4, 0, 0);
    run_instr(1, 0, 0);
    run_instr(5, 0, 0);
    do_fetch(0);
    issue(1'b0, 2'b01, rfn(), 1'b1, 1);
    issue(1'b0, rop(), 6'b000000, 1'b1, 2);
    issue(1'b0, rop(), rfn(), 1'b0, 5);
    issue(1'b0, rop(), rfn(), 1'b0, 5);
    issue(1'b1, rop(), rfn(), 1'b0, 0);
    run_instr(0, 0, 0);
    for (int n = 0; n < 160; n++) begin
      if ($urandom_range(0, 39) == 0) issue(1'b1, rop(), rfn(), rmr(), 0);
      run_instr($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      c = stim_q.pop_front();
      reset = ~c.rst;
      bus.Op = c.op;
      bus.Funct = c.funct;
      bus.MemReady = c.mr;
    end
  end

  // Monitor: one expectation per cycle, sampled at the falling edge.
  initial begin
    cyc_t c;
    int cyc;
    logic [13:0] want;
    logic [13:0] got;
    cyc = 0;
    #1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      c = exp_q.pop_front();
      want = exp_out(c.rst, c.st, c.mr);
      got = {bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
             bus.ALUOp, bus.RegW, bus.MemW, bus.Branch, bus.Illegal};
      total++;
      if (bus.State !== 4'(c.st)) begin
        bad++;
        $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, bus.State, c.st);
      end
      total++;
      if (bus.Instret !== W'(c.ir)) begin
        bad++;
        $display("FAIL instret cyc=%0d got=%0d exp=%0d", cyc, bus.Instret, c.ir);
      end
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL ctrl cyc=%0d state=%0d got=%b exp=%b", cyc, c.st, got, want);
      end
      cyc++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
